// File: rtl/frame_update_scheduler.sv
// Sequences per-frame client updates into vertical blanking with a one-hot req/done handshake,
// per-client timeout, and sticky fault/overrun status. Optional macro FRAME_SKIP_EN adds frame_div.
module frame_update_scheduler #(
  parameter int         NUM_CLIENTS    = 4,
  parameter logic [9:0] ACTIVE_LINES   = 10'd480,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter int         TIMEOUT_W      = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [9:0]             ypos,
  input  logic [NUM_CLIENTS-1:0] skip_mask,
  input  logic [NUM_CLIENTS-1:0] done,
  input  logic                   clear_status,
`ifdef FRAME_SKIP_EN
  input  logic [3:0]             frame_div,
`endif
  output logic [NUM_CLIENTS-1:0] req,
  output logic                   busy,
  output logic                   frame_tick,
  output logic [15:0]            frame_count,
  output logic [NUM_CLIENTS-1:0] fault,
  output logic                   overrun
);

  localparam int IDX_W = $clog2(NUM_CLIENTS + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCAN     = 2'd1,
    ST_REQ      = 2'd2,
    ST_COMPLETE = 2'd3
  } state_t;

  state_t                 state_r;
  logic [IDX_W-1:0]       idx_r;
  logic [TIMEOUT_W-1:0]   tcount_r;
  logic [NUM_CLIENTS-1:0] req_r;
  logic [NUM_CLIENTS-1:0] fault_r;
  logic                   overrun_r;
  logic                   frame_tick_r;
  logic [15:0]            frame_count_r;
  logic                   blank_d_r;

  logic                   blank_s;
  logic                   entry_s;
  logic                   start_s;
  logic                   granted_done_s;
  logic                   skip_hit_s;
  logic                   timeout_s;

  assign blank_s        = (ypos >= ACTIVE_LINES);
  assign entry_s        = blank_s & ~blank_d_r & enable;
  // req is one-hot on idx, so masking done with it honours only the granted client
  assign granted_done_s = |(done & req_r);
  assign timeout_s      = (tcount_r == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  // Select the skip bit of the client currently addressed by idx
  always_comb begin
    skip_hit_s = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (idx_r == IDX_W'(i)) begin
        skip_hit_s = skip_mask[i];
      end else begin
        skip_hit_s = skip_hit_s;
      end
    end
  end

`ifdef FRAME_SKIP_EN
  logic [3:0] div_cnt_r;

  // Count every enabled blank entry, busy or not, so only every (frame_div+1)th entry may start
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt_r <= 4'd0;
    end else if (entry_s) begin
      div_cnt_r <= (div_cnt_r == frame_div) ? 4'd0 : div_cnt_r + 4'd1;
    end
  end

  assign start_s = entry_s & (div_cnt_r == 4'd0);
`else
  assign start_s = entry_s;
`endif

  // Sequencer: blanking edge detect, grant walk, timeout, overrun and completion bookkeeping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      idx_r         <= '0;
      tcount_r      <= '0;
      req_r         <= '0;
      fault_r       <= '0;
      overrun_r     <= 1'b0;
      frame_tick_r  <= 1'b0;
      frame_count_r <= 16'd0;
      blank_d_r     <= 1'b1;
    end else begin
      blank_d_r    <= blank_s;
      frame_tick_r <= 1'b0;
      if (clear_status) begin
        fault_r   <= '0;
        overrun_r <= 1'b0;
      end
      // Losing blanking outranks every in-sequence event, including completion
      if ((state_r != ST_IDLE) && !blank_s) begin
        req_r     <= '0;
        overrun_r <= 1'b1;
        state_r   <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start_s) begin
              idx_r   <= '0;
              state_r <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            if (idx_r == IDX_W'(NUM_CLIENTS)) begin
              state_r <= ST_COMPLETE;
            end else if (skip_hit_s) begin
              idx_r <= idx_r + IDX_W'(1);
            end else begin
              req_r    <= NUM_CLIENTS'(1) << idx_r;
              tcount_r <= '0;
              state_r  <= ST_REQ;
            end
          end
          ST_REQ: begin
            if (granted_done_s) begin
              req_r   <= '0;
              idx_r   <= idx_r + IDX_W'(1);
              state_r <= ST_SCAN;
            end else if (timeout_s) begin
              fault_r <= fault_r | req_r;
              req_r   <= '0;
              idx_r   <= idx_r + IDX_W'(1);
              state_r <= ST_SCAN;
            end else begin
              tcount_r <= tcount_r + TIMEOUT_W'(1);
            end
          end
          ST_COMPLETE: begin
            // Tick and count become visible together on the first IDLE cycle
            frame_tick_r  <= 1'b1;
            frame_count_r <= frame_count_r + 16'd1;
            state_r       <= ST_IDLE;
          end
          default: begin
            req_r   <= '0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign req         = req_r;
  assign busy        = (state_r != ST_IDLE);
  assign frame_tick  = frame_tick_r;
  assign frame_count = frame_count_r;
  assign fault       = fault_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Scoreboard bench for frame_update_scheduler: stimulus pushes expected grants and frame counts,
// a negedge monitor pops and compares them as the DUT presents req changes and frame_tick pulses.
`timescale 1ns/1ps
module tb_frame_update_scheduler;
  localparam int NC = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [9:0]    ypos;
  logic [NC-1:0] skip_mask;
  logic [NC-1:0] done;
  logic          clear_status;
  logic [NC-1:0] req;
  logic          busy;
  logic          frame_tick;
  logic [15:0]   frame_count;
  logic [NC-1:0] fault;
  logic          overrun;
`ifdef FRAME_SKIP_EN
  logic [3:0]    frame_div;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [NC-1:0] exp_req_q[$];
  logic [15:0]   exp_cnt_q[$];
  logic [NC-1:0] hang;
  int            held[NC];

  always #5 clock = ~clock;

  frame_update_scheduler #(
    .NUM_CLIENTS(NC), .ACTIVE_LINES(10'd480), .TIMEOUT_CYCLES(64), .TIMEOUT_W(8)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .ypos(ypos),
    .skip_mask(skip_mask), .done(done), .clear_status(clear_status),
`ifdef FRAME_SKIP_EN
    .frame_div(frame_div),
`endif
    .req(req), .busy(busy), .frame_tick(frame_tick), .frame_count(frame_count),
    .fault(fault), .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (busy && k < 400);
    if (busy) expire(name);
  endtask

  task automatic wait_req(input logic [NC-1:0] v, input string name);
    int k = 0;
    while (req !== v && k < 400) begin
      @(negedge clock);
      k++;
    end
    if (req !== v) expire(name);
  endtask

  task automatic enter_blank();
    ypos = 10'd100;
    cyc(3);
    ypos = 10'd480;
  endtask

  task automatic push_full(input logic [15:0] cnt);
    exp_req_q.push_back(4'b0001);
    exp_req_q.push_back(4'b0010);
    exp_req_q.push_back(4'b0100);
    exp_req_q.push_back(4'b1000);
    exp_cnt_q.push_back(cnt);
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    cyc(1);
    clear_status = 1'b0;
  endtask

  // Client model: raise done on the third cycle of its grant unless told to hang
  initial begin
    done = '0;
    for (int i = 0; i < NC; i++) held[i] = 0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < NC; i++) begin
        if (req[i] === 1'b1) held[i]++;
        else held[i] = 0;
        done[i] = (req[i] === 1'b1) && (held[i] >= 3) && !hang[i];
      end
    end
  end

  // Monitor: invariants every cycle, scoreboard pops on new grants and on frame_tick
  initial begin
    logic [NC-1:0] prev;
    prev = '0;
    forever begin
      @(negedge clock);
      n_checks++;
      if (!$onehot0(req) || (!busy && req != '0)) begin
        n_fail++;
        $display("FAIL req_invariant: req=%b busy=%b", req, busy);
      end
      if (req != '0 && req != prev) begin
        if (exp_req_q.size() == 0) expire("unexpected_req");
        else check("req_order", 32'(req), 32'(exp_req_q.pop_front()));
      end
      prev = req;
      if (frame_tick) begin
        if (exp_cnt_q.size() == 0) expire("unexpected_frame_tick");
        else check("frame_count_at_tick", 32'(frame_count), 32'(exp_cnt_q.pop_front()));
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b0; enable = 1'b1; ypos = 10'd100; skip_mask = '0;
    clear_status = 1'b0; hang = '0;
`ifdef FRAME_SKIP_EN
    frame_div = 4'd0;
`endif
    cyc(2);
    check("rst_req", 32'(req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(frame_count), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b1;
    cyc(3);

    // 1: full sequence, two-cycle grant latency
    push_full(16'd1);
    ypos = 10'd480;
    cyc(1);
    check("t1_scan_req", 32'(req), 32'd0);
    check("t1_scan_busy", 32'(busy), 32'd1);
    cyc(1);
    check("t1_first_req", 32'(req), 32'b0001);
    wait_idle("t1_idle");
    check("t1_fault", 32'(fault), 32'd0);
    check("t1_count", 32'(frame_count), 32'd1);

    // 2: client 2 hangs until timeout
    hang = 4'b0100;
    push_full(16'd2);
    enter_blank();
    wait_req(4'b0100, "t2_wait_req2");
    k = 0;
    while (req[2] === 1'b1 && k < 200) begin
      k++;
      @(negedge clock);
    end
    check("t2_req2_cycles", 32'(k), 32'd64);
    wait_idle("t2_idle");
    check("t2_fault", 32'(fault), 32'b0100);
    check("t2_count", 32'(frame_count), 32'd2);
    hang = '0;
    pulse_clear();
    check("t2_fault_cleared", 32'(fault), 32'd0);

    // 3: skip clients 1 and 3
    skip_mask = 4'b1010;
    exp_req_q.push_back(4'b0001);
    exp_req_q.push_back(4'b0100);
    exp_cnt_q.push_back(16'd3);
    enter_blank();
    wait_req(4'b0100, "t3_wait_req2");
    wait_req(4'b0000, "t3_wait_req2_drop");
    k = 0;
    while (frame_tick !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("t3_tick_delay", 32'(k), 32'd3);
    wait_idle("t3_idle");
    skip_mask = '0;

    // 4: blanking ends while client 1 is granted
    exp_req_q.push_back(4'b0001);
    exp_req_q.push_back(4'b0010);
    enter_blank();
    wait_req(4'b0010, "t4_wait_req1");
    ypos = 10'd0;
    cyc(1);
    check("t4_req", 32'(req), 32'd0);
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_count", 32'(frame_count), 32'd3);
    cyc(3);
    push_full(16'd4);
    enter_blank();
    wait_idle("t4_rerun_idle");
    check("t4_rerun_count", 32'(frame_count), 32'd4);
    pulse_clear();
    check("t4_overrun_cleared", 32'(overrun), 32'd0);

    // 5: asynchronous reset mid-REQ, release inside blanking
    exp_req_q.push_back(4'b0001);
    enter_blank();
    wait_req(4'b0001, "t5_wait_req0");
    #2 reset = 1'b0;
    #1;
    check("t5_async_req", 32'(req), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    ypos = 10'd500;
    @(negedge clock);
    check("t5_count_reset", 32'(frame_count), 32'd0);
    reset = 1'b1;
    cyc(10);
    check("t5_no_start_req", 32'(req), 32'd0);
    check("t5_no_start_busy", 32'(busy), 32'd0);
    push_full(16'd1);
    enter_blank();
    wait_idle("t5_rerun_idle");
    check("t5_rerun_count", 32'(frame_count), 32'd1);

    // 6: disabled blank entry is ignored
    enable = 1'b0;
    enter_blank();
    cyc(8);
    check("t6_disabled_busy", 32'(busy), 32'd0);
    check("t6_disabled_req", 32'(req), 32'd0);
    enable = 1'b1;
    ypos = 10'd100;
    cyc(3);
`ifdef FRAME_SKIP_EN
    frame_div = 4'd1;
    for (int e = 0; e < 4; e++) begin
      if (e % 2 == 0) push_full(16'(2 + e / 2));
      enter_blank();
      wait_idle("t6_div_idle");
      cyc(2);
    end
    check("t6_div_count", 32'(frame_count), 32'd3);
    frame_div = 4'd0;
`endif

    ypos = 10'd100;
    cyc(4);
    check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    check("count_queue_drained", 32'(exp_cnt_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
